// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer: serialises bitstream words into a ccff chain
// and optionally reads the chain back through a loopback to verify the load.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 36,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [CNT_W-1:0]  err_cnt
);

   // state  | meaning
   // IDLE   | waiting for start, chain clock gated
   // LOAD   | accepting words and shifting them into the chain
   // VERIFY | CHAIN_LEN-cycle loopback readback against the shadow copy
   // DONE   | one-cycle completion pulse
   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

   localparam int WBL_W = $clog2(WORD_W + 1);

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       vcnt;
   logic [WBL_W-1:0]       word_bits_left;
   logic [WORD_W-1:0]      word_buf;
   logic [CHAIN_LEN-1:0]   shadow;
   logic                   verify_lat;
   logic [CNT_W-1:0]       bits_rem;
   logic [WBL_W-1:0]       load_n;

   assign bits_rem = CNT_W'(CHAIN_LEN) - bit_cnt;
   assign load_n   = (32'(bits_rem) < WORD_W) ? WBL_W'(bits_rem) : WBL_W'(WORD_W);

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         vcnt           <= '0;
         word_bits_left <= '0;
         word_buf       <= '0;
         shadow         <= '0;
         verify_lat     <= 1'b0;
         verify_err     <= 1'b0;
         err_cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= LOAD;
                  bit_cnt        <= '0;
                  err_cnt        <= '0;
                  verify_err     <= 1'b0;
                  shadow         <= '0;
                  word_bits_left <= '0;
                  verify_lat     <= verify_en;
               end
            end
            LOAD: begin
               if (word_bits_left != '0) begin
                  word_buf              <= word_buf >> 1;
                  word_bits_left        <= word_bits_left - WBL_W'(1);
                  bit_cnt               <= bit_cnt + CNT_W'(1);
                  shadow                <= shadow >> 1;
                  shadow[CHAIN_LEN-1]   <= word_buf[0];
               end else if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
                  if (verify_lat) begin
                     state <= VERIFY;
                     vcnt  <= CNT_W'(CHAIN_LEN - 1);
                  end else begin
                     state <= DONE;
                  end
               end else if (cfg_valid) begin
                  word_buf       <= cfg_data;
                  word_bits_left <= load_n;
               end
            end
            VERIFY: begin
               // oldest shadow bit sits at index 0; rotating keeps it for a re-run
               if (ccff_tail != shadow[0]) begin
                  verify_err <= 1'b1;
                  if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
               end
               shadow              <= shadow >> 1;
               shadow[CHAIN_LEN-1] <= shadow[0];
               if (vcnt == '0) state <= DONE;
               else            vcnt  <= vcnt - CNT_W'(1);
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg_ready     = (state == LOAD) && (word_bits_left == '0) &&
                          (bit_cnt < CNT_W'(CHAIN_LEN));
   assign ccff_shift_en = ((state == LOAD) && (word_bits_left != '0)) || (state == VERIFY);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   always_comb begin
      ccff_head = 1'b0;
      if (state == LOAD && word_bits_left != '0) ccff_head = word_buf[0];
      else if (state == VERIFY)                  ccff_head = ccff_tail;
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader against a behavioural 36-flop chain.
module tb_ccff_chain_loader;

   localparam int CL = 36;

   logic        prog_clk = 1'b0;
   logic        prog_rst_n;
   logic        start, verify_en, cfg_valid;
   logic [7:0]  cfg_data;
   logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
   logic        busy, done, verify_err;
   logic [5:0]  err_cnt;

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .verify_en(verify_en),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .verify_err(verify_err), .err_cnt(err_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   // chain[0] is the flop next to ccff_head, chain[35] drives ccff_tail
   logic [CL-1:0] chain = '0;
   int            shift_total = 0;
   int            shift_base = 0;
   bit            fault_en = 1'b0;
   assign ccff_tail = chain[CL-1];

   // the faulty flop 10 comes out of the load holding 1
   always @(posedge prog_clk) begin
      logic [CL-1:0] nxt;
      if (ccff_shift_en) begin
         nxt = {chain[CL-2:0], ccff_head};
         if (fault_en && (shift_total - shift_base) == CL - 1) nxt[10] = 1'b1;
         chain       <= nxt;
         shift_total <= shift_total + 1;
      end
   end

   int n_chk = 0, n_pass = 0;
   logic [7:0] words [5];
   int hs, viol, done_edge;
   logic [5:0] err_at;
   logic verr_at, busy_at, busy_after, done_after;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_words(input logic [7:0] a, b, c, d, e);
      words[0] = a; words[1] = b; words[2] = c; words[3] = d; words[4] = e;
   endtask

   function automatic logic [CL-1:0] exp_chain();
      logic [CL-1:0] c;
      for (int k = 0; k < CL; k++) c[CL-1-k] = words[k/8][k%8];
      return c;
   endfunction

   task automatic run_pass(input bit ver, input bit gaps, input bit poke_start);
      int bl, lbits, cyc, idx;
      bit acc, exp_se, exp_rdy, in_load, fin;
      shift_base = shift_total;
      hs = 0; viol = 0; done_edge = -1;
      start = 1'b1; verify_en = ver;
      @(posedge prog_clk); #1;
      start = 1'b0; verify_en = 1'b0;
      bl = 0; lbits = 0; in_load = 1'b1; cyc = 0; idx = 0; fin = 1'b0;
      while (!fin && cyc < 400) begin
         cfg_valid = (idx < 5) && (!gaps || $urandom_range(0, 1) == 1);
         cfg_data  = (idx < 5) ? words[idx] : 8'h00;
         exp_se    = 1'b0;
         acc       = 1'b0;
         if (done) begin
            fin = 1'b1; done_edge = cyc;
            err_at = err_cnt; verr_at = verify_err; busy_at = busy;
         end else begin
            if (in_load) begin
               exp_se  = (bl > 0);
               exp_rdy = (bl == 0) && (lbits < CL);
               if (ccff_shift_en !== exp_se || cfg_ready !== exp_rdy) viol++;
            end else if (ccff_shift_en !== ver || cfg_ready !== 1'b0) begin
               viol++;
            end
            start = poke_start && (cyc == 10 || cyc == 60);
            acc   = cfg_valid && cfg_ready;
            @(posedge prog_clk); #1;
            cyc++;
            if (in_load) begin
               if (exp_se) begin bl--; lbits++; end
               if (acc) begin
                  hs++; idx++;
                  bl = (CL - lbits < 8) ? CL - lbits : 8;
               end
               if (lbits == CL && bl == 0 && !exp_se) in_load = 1'b0;
            end
         end
      end
      cfg_valid = 1'b0; start = 1'b0;
      @(posedge prog_clk); #1;
      busy_after = busy; done_after = done;
   endtask

   initial begin
      prog_rst_n = 1'b0; start = 1'b0; verify_en = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      repeat (2) @(posedge prog_clk); #1;
      chk("rst_ready", cfg_ready, 0);
      chk("rst_head", ccff_head, 0);
      chk("rst_shift_en", ccff_shift_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_verr", verify_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge prog_clk); prog_rst_n = 1'b1;
      @(posedge prog_clk); #1;

      // load only, valid held high
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h09);
      run_pass(1'b0, 1'b0, 1'b0);
      chk("p1_handshakes", hs, 5);
      chk("p1_shifts", shift_total - shift_base, 36);
      chk("p1_done_edge", done_edge, 42);
      chk("p1_protocol", viol, 0);
      chk("p1_chain", chain, 36'h9_00FF_3CA5 & 36'hF_FFFF_FFFF ? exp_chain() : exp_chain());
      chk("p1_chain_lit", chain, 36'b1010_0101_0011_1100_1111_1111_0000_0000_1001);
      chk("p1_busy_at_done", busy_at, 1);
      chk("p1_busy_after", busy_after, 0);
      chk("p1_done_after", done_after, 0);

      // clean verify with stray start pulses in LOAD and VERIFY
      run_pass(1'b1, 1'b0, 1'b1);
      chk("p2_shifts", shift_total - shift_base, 72);
      chk("p2_done_edge", done_edge, 78);
      chk("p2_handshakes", hs, 5);
      chk("p2_protocol", viol, 0);
      chk("p2_err_cnt", err_at, 0);
      chk("p2_verr", verr_at, 0);
      chk("p2_chain", chain, exp_chain());

      // flop 10 stuck high, zero data
      fault_en = 1'b1;
      set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_pass(1'b1, 1'b0, 1'b0);
      chk("f0_err_cnt", err_at, 1);
      chk("f0_verr", verr_at, 1);

      // flop 10 stuck high, 0x55 data: stream bit 25 (a zero) lands there
      set_words(8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
      run_pass(1'b1, 1'b0, 1'b0);
      chk("f55_err_cnt", err_at, 1);
      chk("f55_verr", verr_at, 1);
      fault_en = 1'b0;

      // random valid gaps
      set_words(8'h6B, 8'hD2, 8'h81, 8'h7E, 8'h0C);
      run_pass(1'b1, 1'b1, 1'b0);
      chk("gap_handshakes", hs, 5);
      chk("gap_shifts", shift_total - shift_base, 72);
      chk("gap_protocol", viol, 0);
      chk("gap_err_cnt", err_at, 0);
      chk("gap_chain", chain, exp_chain());

      // reset after 20 load shifts
      shift_base = shift_total;
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hFF;
      for (int i = 0; i < 100 && (shift_total - shift_base) < 20; i++) begin
         @(posedge prog_clk); #1;
      end
      chk("mid_shifts", shift_total - shift_base, 20);
      #2 prog_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cfg_ready, 0);
      chk("mid_rst_shift_en", ccff_shift_en, 0);
      chk("mid_rst_head", ccff_head, 0);
      chk("mid_rst_done", done, 0);
      cfg_valid = 1'b0;
      @(negedge prog_clk); prog_rst_n = 1'b1;
      @(posedge prog_clk); #1;
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h09);
      run_pass(1'b1, 1'b0, 1'b0);
      chk("reload_shifts", shift_total - shift_base, 72);
      chk("reload_err_cnt", err_at, 0);
      chk("reload_chain", chain, 36'b1010_0101_0011_1100_1111_1111_0000_0000_1001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
